// File: rtl/adc_acq_seq.sv
// Round-robin ADC acquisition sequencer: drives channel select/soc, converts offset-binary
// results to two's complement, optionally accumulates frames, and emits a valid/ready frame.
module adc_acq_seq #(
  parameter int NCH      = 2,
  parameter int ADC_W    = 12,
  parameter int SEL_W    = 3,
  parameter int AVG_LOG2 = 0,
  parameter int OUT_W    = ADC_W + AVG_LOG2,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk_adc,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [NCH*SEL_W-1:0] chan_map,
  output logic [SEL_W-1:0]     adc_s,
  output logic                 adc_soc,
  input  logic                 adc_eoc,
  input  logic [ADC_W-1:0]     adc_dout,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [NCH*OUT_W-1:0] frame_data,
  output logic                 overrun,
  output logic                 timeout,
  input  logic                 err_clr
);

  localparam int SLOT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AVG_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NCH - 1);
  localparam logic [AVG_W-1:0]  AVG_LAST  = AVG_W'((1 << AVG_LOG2) - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_RECOV = 2'd2;

  logic [1:0]              state;
  logic [SLOT_W-1:0]       slot;
  logic [SLOT_W-1:0]       slot_nxt;
  logic [AVG_W-1:0]        avg_cnt;
  logic [TCNT_W-1:0]       tcnt;
  logic signed [OUT_W-1:0] acc [NCH];
  logic [SEL_W-1:0]        map [NCH];

  logic signed [ADC_W-1:0] sample_raw;
  logic signed [OUT_W-1:0] sample;
  logic signed [OUT_W-1:0] acc_sum;
  logic [NCH*OUT_W-1:0]    frame_nxt;
  logic                    conv_eoc;
  logic                    frame_done;
  logic                    out_free;
  logic                    tout_hit;

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      map[k] = chan_map[k*SEL_W +: SEL_W];
    end
  end

  assign adc_soc    = (state == S_CONV);
  assign sample_raw = {~adc_dout[ADC_W-1], adc_dout[ADC_W-2:0]};
  assign sample     = OUT_W'(sample_raw);
  assign acc_sum    = (avg_cnt == '0) ? sample : acc[slot] + sample;
  assign slot_nxt   = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
  assign conv_eoc   = (state == S_CONV) && adc_eoc && enable;
  assign frame_done = conv_eoc && (slot == LAST_SLOT) && (avg_cnt == AVG_LAST);
  assign out_free   = !frame_valid || frame_ready;
  assign tout_hit   = (state == S_CONV) && !adc_eoc && (tcnt == TCNT_LAST);

  // The final sample is still in flight when the frame completes, so splice it in here.
  always_comb begin
    frame_nxt = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      frame_nxt[k*OUT_W +: OUT_W] = (SLOT_W'(k) == slot) ? acc_sum : acc[k];
    end
  end

  always_ff @(posedge clk_adc or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      slot    <= '0;
      avg_cnt <= '0;
      tcnt    <= '0;
      adc_s   <= '0;
      for (int unsigned k = 0; k < NCH; k++) acc[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tcnt <= '0;
          if (enable) begin
            state   <= S_CONV;
            slot    <= '0;
            avg_cnt <= '0;
            adc_s   <= map[0];
          end
        end
        S_CONV: begin
          if (adc_eoc) begin
            tcnt <= '0;
            if (!enable) begin
              state <= S_IDLE;
            end else begin
              acc[slot] <= acc_sum;
              slot      <= slot_nxt;
              adc_s     <= map[slot_nxt];
              if (slot == LAST_SLOT) begin
                avg_cnt <= (avg_cnt == AVG_LAST) ? '0 : avg_cnt + 1'b1;
              end
            end
          end else if (tout_hit) begin
            tcnt  <= '0;
            state <= S_RECOV;
            adc_s <= map[0];
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RECOV: begin
          slot    <= '0;
          avg_cnt <= '0;
          tcnt    <= '0;
          adc_s   <= map[0];
          for (int unsigned k = 0; k < NCH; k++) acc[k] <= '0;
          state   <= enable ? S_CONV : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_adc or negedge rstn) begin
    if (!rstn) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else if (frame_done && out_free) begin
      frame_valid <= 1'b1;
      frame_data  <= frame_nxt;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  // Setting wins over err_clr in the same cycle.
  always_ff @(posedge clk_adc or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (err_clr) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
      end
      if (frame_done && !out_free) overrun <= 1'b1;
      if (tout_hit) timeout <= 1'b1;
    end
  end

endmodule
